// File: rtl/mem_pkg.sv
// Shared op encodings, FSM states and lane helpers for the MEM-stage access unit.
package mem_pkg;

  localparam int WORD_AW_DEF = 8;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } req_t;

  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LBU;
  endfunction

  function automatic logic is_rmw(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  op_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] ins_mask;

  assign sh   = {off_i, 3'b000};
  assign lane = word_i >> sh;

  always_comb begin
    load_o = word_i;
    case (op_i)
      OP_LH:   load_o = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_o = lane & HALF_LANE_MASK;
      OP_LB:   load_o = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_o = lane & BYTE_LANE_MASK;
      default: load_o = word_i;
    endcase
  end

  assign ins_mask = ((op_i == OP_SH) ? HALF_LANE_MASK : BYTE_LANE_MASK) << sh;
  assign merge_o  = (word_i & ~ins_mask) | ((wdata_i << sh) & ins_mask);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: byte-addressed loads/stores onto word memory, RMW for SB/SH.
// Load result two edges after acceptance; ex_ready drops during the SB/SH read/merge.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_AW = WORD_AW_DEF,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_op,
  input  logic [31:0]       ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [31:0]       Addr,
  output logic [DATA_W-1:0] wData,
  input  logic [DATA_W-1:0] rData,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              misalign_err
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [DATA_W-1:0] mbuf_q, wb_data_q;
  logic [4:0]        wb_rd_q;
  logic              wb_valid_q, mis_q;
  logic              accept, mis_now, take;
  logic [DATA_W-1:0] align_word, load_val, merge_val;
  logic              unused_addr_hi;

  assign ex_ready = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && !is_rmw(req_q.op));
  assign accept   = ex_valid && ex_ready;
  assign mis_now  = is_misaligned(ex_op, ex_addr[1:0]);
  assign take     = accept && !mis_now;

  // Bits above the word index wrap away.
  assign unused_addr_hi = ^req_q.addr[31:WORD_AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = take ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = is_rmw(req_q.op) ? ST_MERGE : (take ? ST_ACCESS : ST_IDLE);
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    Addr     = '0;
    wData    = '0;
    if (state_q == ST_ACCESS) begin
      ReadMem  = (req_q.op != OP_SW);
      WriteMem = (req_q.op == OP_SW);
      wData    = (req_q.op == OP_SW) ? req_q.wdata : '0;
    end else if (state_q == ST_MERGE) begin
      WriteMem = 1'b1;
      wData    = merge_val;
    end
    if (ReadMem || WriteMem) Addr = {{(32-WORD_AW){1'b0}}, req_q.addr[WORD_AW+1:2]};
  end

  // The lane unit sees live read data for loads and the buffered word while merging.
  assign align_word = (state_q == ST_MERGE) ? mbuf_q : rData;

  byte_lane_align u_align (
    .word_i  (align_word),
    .wdata_i (req_q.wdata),
    .off_i   (req_q.addr[1:0]),
    .op_i    (req_q.op),
    .load_o  (load_val),
    .merge_o (merge_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      mbuf_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      mis_q      <= accept && mis_now;
      wb_valid_q <= 1'b0;
      if (take) req_q <= '{op: ex_op, addr: ex_addr, wdata: ex_wdata, rd: ex_rd};
      if ((state_q == ST_ACCESS) && is_load(req_q.op)) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= load_val;
        wb_rd_q    <= req_q.rd;
      end
      if ((state_q == ST_ACCESS) && is_rmw(req_q.op)) mbuf_q <= rData;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory, byte-level reference model, directed and random traffic.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        ReadMem, WriteMem;
  logic [31:0] Addr, wData, rData;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_AW(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .Addr(Addr), .wData(wData), .rData(rData),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign_err(misalign_err)
  );

  // Data memory seen by the DUT
  logic [31:0] mem [256];
  logic        pre_we = 1'b0, mem_clr = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_dat = 32'd0;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    else if (pre_we) mem[pre_idx] <= pre_dat;
    else if (WriteMem) mem[Addr[7:0]] <= wData;
  end
  assign rData = ReadMem ? mem[Addr[7:0]] : 32'h0;

  int checks = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte memory semantics, in-order effects applied at acceptance
  typedef struct { int due; logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct { int c; logic [4:0] rd; logic [31:0] data; } wb_obs_t;
  logic [31:0] refmem [256];
  wb_exp_t wbq[$];
  int      misq[$];
  wb_obs_t wb_log[$];
  int      mis_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  bit      model_en = 1'b1;
  int      last_acc = 0;

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w, input int off);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (op)
      OP_LW:   return w;
      OP_LB:   return (b >= 128) ? b + 32'hFFFFFF00 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h + 32'hFFFF0000 : h;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] op, input logic [31:0] old,
                                              input logic [31:0] wd, input int off);
    logic [7:0] by [4];
    for (int k = 0; k < 4; k++) by[k] = 8'(old >> (8 * k));
    if (op == OP_SW) return wd;
    by[off] = wd[7:0];
    if (op == OP_SH) by[off + 1] = wd[15:8];
    return {by[3], by[2], by[1], by[0]};
  endfunction

  function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] addr);
    int unsigned a;
    a = addr;
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  task automatic record(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int acc);
    int idx;
    idx = int'((addr / 4) % 256);
    if (model_misaligned(op, addr)) misq.push_back(acc);
    else if (op <= OP_LBU) wbq.push_back('{acc + 1, rd, model_load(op, refmem[idx], int'(addr % 4))});
    else refmem[idx] = model_store(op, refmem[idx], wd, int'(addr % 4));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after the accepting edge.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd);
    bit done;
    done = 1'b0;
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    for (int t = 0; t < 8 && !done; t++) begin
      #1;
      if (ex_ready) begin
        done = 1'b1;
        last_acc = cyc + 1;
        if (model_en) record(op, addr, wd, rd, last_acc);
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout: op=%0d addr=%08h ex_ready=0 expected 1 within 8 cycles", op, addr);
    end
  endtask

  task automatic go_idle();
    ex_valid = 1'b0;
    ex_op = 3'($urandom); ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pre_we = 1'b1; pre_idx = 8'(idx); pre_dat = v;
    refmem[idx] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic expect_load(input string name, input logic [31:0] v, input logic [4:0] rd);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      if (wb_valid) begin
        seen = 1'b1;
        chk(name, wb_data, v);
        chk({name, "_rd"}, 32'(wb_rd), 32'(rd));
      end else @(negedge clk);
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL %s: wb_valid=0 expected 1 within 6 cycles", name);
    end
  endtask

  // Cycle-by-cycle compare against the model
  bit exp_wb, exp_mis;
  always @(negedge clk) begin
    if (!rst) begin
      exp_wb  = (wbq.size() > 0) && (wbq[0].due == cyc);
      exp_mis = (misq.size() > 0) && (misq[0] == cyc);
      checks++;
      if (wb_valid !== exp_wb) begin
        fails++;
        $display("FAIL wb_valid cyc=%0d: got %b expected %b", cyc, wb_valid, exp_wb);
      end else if (exp_wb && (wb_data !== wbq[0].data || wb_rd !== wbq[0].rd)) begin
        fails++;
        $display("FAIL wb_result cyc=%0d: got rd=%0d data=%08h expected rd=%0d data=%08h",
                 cyc, wb_rd, wb_data, wbq[0].rd, wbq[0].data);
      end
      if (exp_wb) void'(wbq.pop_front());
      checks++;
      if (misalign_err !== exp_mis) begin
        fails++;
        $display("FAIL misalign_err cyc=%0d: got %b expected %b", cyc, misalign_err, exp_mis);
      end
      if (exp_mis) void'(misq.pop_front());
      checks++;
      if ((ReadMem && WriteMem) || (!ReadMem && !WriteMem && Addr != 0) || (!WriteMem && wData != 0)) begin
        fails++;
        $display("FAIL mem_if cyc=%0d: got rd=%b wr=%b addr=%08h wdata=%08h expected exclusive enables, zero when idle",
                 cyc, ReadMem, WriteMem, Addr, wData);
      end
      if (wb_valid) wb_log.push_back('{cyc, wb_rd, wb_data});
      if (misalign_err) mis_cnt++;
      if (ReadMem) rd_cnt++;
      if (WriteMem) wr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "timeout");
  end

  logic [2:0]  r_op;
  logic [31:0] r_addr;

  initial begin
    go_idle();
    rst = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) refmem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_readmem", 32'(ReadMem), 32'd0);
    chk("rst_writemem", 32'(WriteMem), 32'd0);
    chk("rst_addr", Addr, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Load extension
    preload(50, 32'h80FF7F01);
    chk("model_lb201", model_load(OP_LB, refmem[50], 1), 32'h0000007F);
    chk("model_lh202", model_load(OP_LH, refmem[50], 2), 32'hFFFF80FF);
    do_req(OP_LB, 32'd201, 32'd0, 5'd1);  go_idle(); expect_load("lb_201", 32'h0000007F, 5'd1);
    do_req(OP_LB, 32'd203, 32'd0, 5'd2);  go_idle(); expect_load("lb_203", 32'hFFFFFF80, 5'd2);
    do_req(OP_LBU, 32'd203, 32'd0, 5'd3); go_idle(); expect_load("lbu_203", 32'h00000080, 5'd3);
    do_req(OP_LH, 32'd202, 32'd0, 5'd4);  go_idle(); expect_load("lh_202", 32'hFFFF80FF, 5'd4);
    do_req(OP_LHU, 32'd202, 32'd0, 5'd5); go_idle(); expect_load("lhu_202", 32'h000080FF, 5'd5);
    @(negedge clk);

    // SB read-modify-write
    preload(51, 32'h03020100);
    do_req(OP_SB, 32'd206, 32'h000000AA, 5'd0); go_idle();
    chk("sb_read_en", 32'(ReadMem), 32'd1);
    chk("sb_read_addr", Addr, 32'd51);
    chk("sb_ready_0a", 32'(ex_ready), 32'd0);
    @(negedge clk);
    chk("sb_write_en", 32'(WriteMem), 32'd1);
    chk("sb_wdata", wData, 32'h03AA0100);
    chk("sb_ready_0b", 32'(ex_ready), 32'd0);
    @(negedge clk);
    chk("sb_ready_back", 32'(ex_ready), 32'd1);
    chk("sb_mem51", mem[51], 32'h03AA0100);

    // Back-to-back LW
    preload(52, 32'h00000002);
    wb_log.delete();
    begin
      int a0, a1;
      do_req(OP_LW, 32'd200, 32'd0, 5'd3); a0 = last_acc;
      do_req(OP_LW, 32'd204, 32'd0, 5'd4); a1 = last_acc;
      do_req(OP_LW, 32'd208, 32'd0, 5'd5);
      go_idle();
      chk("b2b_acc_gap1", 32'(a1 - a0), 32'd1);
      chk("b2b_acc_gap2", 32'(last_acc - a1), 32'd1);
      repeat (3) @(negedge clk);
      chk("b2b_wb_count", 32'(wb_log.size()), 32'd3);
      if (wb_log.size() == 3) begin
        chk("b2b_wb_first_cyc", 32'(wb_log[0].c), 32'(a0 + 1));
        chk("b2b_wb_consec", 32'(wb_log[2].c - wb_log[0].c), 32'd2);
        chk("b2b_data0", wb_log[0].data, 32'h80FF7F01);
        chk("b2b_data1", wb_log[1].data, 32'h03AA0100);
        chk("b2b_data2", wb_log[2].data, 32'h00000002);
        chk("b2b_rd2", 32'(wb_log[2].rd), 32'd5);
      end
    end

    // Misalignment
    mis_cnt = 0; rd_cnt = 0; wr_cnt = 0; wb_log.delete();
    do_req(OP_LW, 32'd201, 32'd0, 5'd6); go_idle();
    chk("mis_lw_pulse", 32'(misalign_err), 32'd1);
    do_req(OP_SH, 32'd205, 32'h0000BEEF, 5'd0); go_idle();
    chk("mis_sh_pulse", 32'(misalign_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("mis_count", 32'(mis_cnt), 32'd2);
    chk("mis_no_read", 32'(rd_cnt), 32'd0);
    chk("mis_no_write", 32'(wr_cnt), 32'd0);
    chk("mis_no_wb", 32'(wb_log.size()), 32'd0);
    chk("mis_mem51", mem[51], 32'h03AA0100);

    // Reset during MERGE
    model_en = 1'b0;
    do_req(OP_SB, 32'd208, 32'h00000055, 5'd0); go_idle();
    model_en = 1'b1;
    @(negedge clk);
    chk("rstm_merge_wr", 32'(WriteMem), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm_writemem", 32'(WriteMem), 32'd0);
    chk("rstm_readmem", 32'(ReadMem), 32'd0);
    chk("rstm_addr", Addr, 32'd0);
    chk("rstm_wdata", wData, 32'd0);
    chk("rstm_wb", {wb_data[30:0], wb_valid}, 32'd0);
    chk("rstm_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_mem52", mem[52], 32'h00000002);
    @(negedge clk);
    do_req(OP_LW, 32'd208, 32'd0, 5'd7); go_idle(); expect_load("rstm_lw", 32'h00000002, 5'd7);
    @(negedge clk);

    // Address wrap
    do_req(OP_SW, 32'h00000400, 32'h12345678, 5'd0); go_idle();
    chk("wrap_write_en", 32'(WriteMem), 32'd1);
    chk("wrap_addr", Addr, 32'd0);
    chk("wrap_wdata", wData, 32'h12345678);
    @(negedge clk);
    chk("wrap_mem0", mem[0], 32'h12345678);
    do_req(OP_LW, 32'd0, 32'd0, 5'd9); go_idle(); expect_load("wrap_lw0", 32'h12345678, 5'd9);
    @(negedge clk);

    // Random traffic over a small window so stores and loads collide
    for (int n = 0; n < 400; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_addr = $urandom_range(240, 271);
      if ($urandom_range(0, 3) == 0) r_addr = r_addr + 32'h400 * $urandom_range(1, 8);
      do_req(r_op, r_addr, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        @(negedge clk);
      end
    end
    go_idle();
    repeat (6) @(negedge clk);

    chk("drain_wbq", 32'(wbq.size()), 32'd0);
    chk("drain_misq", 32'(misq.size()), 32'd0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem_final[%0d]", i), mem[i], refmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
